// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state codes and oversampling constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial input, resets to line idle (1)
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_async.sv
// rtl/uart_rx_async.sv - 16x oversampling UART receiver with parity, framing and overflow flags
module uart_rx_async
    import uart_pkg::*;
#(
    parameter int RX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_parity_err,
    input  logic       clear_framing_err,
    input  logic       fifo_full,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       fifo_write,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       rx_idle
);

    rx_state_t  state, state_next;
    logic [3:0] sample_cnt, sample_cnt_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       parity_pend, parity_pend_next;
    logic       break_seen, break_next;
    logic       rx_s;
    logic       done;
    logic       stop_low;
    logic       ovf_set;
    logic [7:0] data_byte;
    logic [2:0] last_bit;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // 7-bit frames land in shift_reg[7:1]; realign so bit 7 reads 0
    assign data_byte = bit8 ? shift_reg : {1'b0, shift_reg[7:1]};
    assign last_bit  = bit8 ? 3'd7 : 3'd6;
    assign rx_idle   = (state == IDLE);
    assign ovf_set   = done && ((RX_FIFO != 0) ? fifo_full : (rx_ready && !read_rx_byte));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= 4'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            parity_pend <= 1'b0;
            break_seen  <= 1'b0;
        end else begin
            state       <= state_next;
            sample_cnt  <= sample_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_pend <= parity_pend_next;
            break_seen  <= break_next;
        end
    end

    always_comb begin
        state_next       = state;
        sample_cnt_next  = sample_cnt;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        parity_pend_next = parity_pend;
        break_next       = break_seen;
        done             = 1'b0;
        stop_low         = 1'b0;
        if (baud_clock) begin
            sample_cnt_next = sample_cnt + 4'd1;
            case (state)
                IDLE: begin
                    sample_cnt_next = 4'd0;
                    // after a break the line must go high before a new start bit counts
                    if (rx_s) begin
                        break_next = 1'b0;
                    end else if (!break_seen) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (sample_cnt == MID_START) begin
                        sample_cnt_next = 4'd0;
                        if (!rx_s) begin
                            state_next       = DATA;
                            bit_cnt_next     = 3'd0;
                            parity_pend_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample_cnt == MID_BIT) begin
                        shift_next   = {rx_s, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == last_bit) begin
                            state_next = parity_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (sample_cnt == MID_BIT) begin
                        if (((^data_byte) ^ rx_s) != odd_n_even) begin
                            parity_pend_next = 1'b1;
                        end
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (sample_cnt == MID_BIT) begin
                        done       = 1'b1;
                        stop_low   = !rx_s;
                        break_next = !rx_s;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte     <= 8'd0;
            rx_ready    <= 1'b0;
            fifo_write  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            fifo_write <= done && (RX_FIFO != 0);
            if (done) begin
                rx_byte <= data_byte;
            end
            if (done && (RX_FIFO == 0)) begin
                rx_ready <= 1'b1;
            end else if (read_rx_byte) begin
                rx_ready <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (read_rx_byte) begin
                overflow <= 1'b0;
            end
            if (done && parity_pend) begin
                parity_err <= 1'b1;
            end else if (clear_parity_err) begin
                parity_err <= 1'b0;
            end
            if (stop_low) begin
                framing_err <= 1'b1;
            end else if (clear_framing_err) begin
                framing_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_async.sv
// tb/tb_uart_rx_async.sv - self-checking bench for uart_rx_async in holding-register and FIFO modes
module tb_uart_rx_async;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] data;
        bit         b8;
        bit         pen;
        bit         odd;
        bit         flip;
        bit         stop_v;
        logic [7:0] exp_byte;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] byte_v;
        bit         perr;
        bit         ferr;
        bit         ovf;
    } exp_t;

    typedef struct {
        logic [7:0] byte_v;
        bit         ovf;
    } fexp_t;

    logic       clk = 1'b0;
    logic       reset, baud_clock;
    logic       rx0, rx1;
    logic       bit8, parity_en, odd_n_even;
    logic       read_rx_byte, clear_parity_err, clear_framing_err, fifo_full;
    logic [7:0] rx_byte0, rx_byte1;
    logic       rx_ready0, fifo_write0, parity_err0, framing_err0, overflow0, rx_idle0;
    logic       rx_ready1, fifo_write1, parity_err1, framing_err1, overflow1, rx_idle1;
    logic [1:0] bdiv;

    int    n_checks = 0;
    int    n_errors = 0;
    int    fw_count = 0;
    int    fw0_count = 0;
    int    lat;
    bit    fw_prev;
    bit    busy;
    exp_t  sb0[$];
    fexp_t sbf[$];
    fexp_t fe;
    vec_t  vt[8];

    always #5 clk = ~clk;

    uart_rx_async #(.RX_FIFO(0)) dut0 (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx0),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity_err(clear_parity_err),
        .clear_framing_err(clear_framing_err), .fifo_full(fifo_full),
        .rx_byte(rx_byte0), .rx_ready(rx_ready0), .fifo_write(fifo_write0),
        .parity_err(parity_err0), .framing_err(framing_err0),
        .overflow(overflow0), .rx_idle(rx_idle0)
    );

    uart_rx_async #(.RX_FIFO(1)) dut1 (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx1),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity_err(clear_parity_err),
        .clear_framing_err(clear_framing_err), .fifo_full(fifo_full),
        .rx_byte(rx_byte1), .rx_ready(rx_ready1), .fifo_write(fifo_write1),
        .parity_err(parity_err1), .framing_err(framing_err1),
        .overflow(overflow1), .rx_idle(rx_idle1)
    );

    initial begin
        bdiv       = 2'd0;
        baud_clock = 1'b0;
        forever begin
            @(negedge clk);
            bdiv       <= bdiv + 2'd1;
            baud_clock <= (bdiv == 2'd3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx1 = v;
        else rx0 = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit b8, input bit pen,
                              input bit odd, input bit flip, input bit stop_v, input int stop_clks);
        logic [7:0] m;
        m = b8 ? d : {1'b0, d[6:0]};
        drive(sel, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            drive(sel, m[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (pen) begin
            drive(sel, (^m) ^ odd ^ flip);
            repeat (BIT_CLKS) @(negedge clk);
        end
        drive(sel, stop_v);
        repeat (stop_clks) @(negedge clk);
        drive(sel, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic check_frame0(input string tag);
        exp_t e;
        chk($sformatf("%s_sb_depth", tag), sb0.size(), 1);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk($sformatf("%s_rx_byte", tag), rx_byte0, e.byte_v);
            chk($sformatf("%s_rx_ready", tag), rx_ready0, 1);
            chk($sformatf("%s_parity_err", tag), parity_err0, e.perr);
            chk($sformatf("%s_framing_err", tag), framing_err0, e.ferr);
            chk($sformatf("%s_overflow", tag), overflow0, e.ovf);
        end
    endtask

    task automatic clear_all();
        read_rx_byte      = 1'b1;
        clear_parity_err  = 1'b1;
        clear_framing_err = 1'b1;
        @(negedge clk);
        read_rx_byte      = 1'b0;
        clear_parity_err  = 1'b0;
        clear_framing_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic align_baud();
        while (bdiv != 2'd0) @(negedge clk);
    endtask

    // FIFO-mode scoreboard: every push strobe pops one expected record
    initial begin
        fw_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_write0) fw0_count++;
            if (fifo_write1) begin
                fw_count++;
                chk("fifo_write_width", fw_prev, 0);
                chk("fifo_sb_nonempty", sbf.size() > 0, 1);
                if (sbf.size() > 0) begin
                    fe = sbf.pop_front();
                    chk("fifo_rx_byte", rx_byte1, fe.byte_v);
                    chk("fifo_overflow", overflow1, fe.ovf);
                end
            end
            fw_prev = fifo_write1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h53, 1'b0, 1'b0};
        vt[2] = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0};
        vt[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[4] = '{8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vt[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[7] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        read_rx_byte = 1'b0; clear_parity_err = 1'b0; clear_framing_err = 1'b0; fifo_full = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rx_idle", rx_idle0, 1);
        chk("reset_rx_ready", rx_ready0, 0);
        chk("reset_rx_byte", rx_byte0, 0);
        chk("reset_flags", {parity_err0, framing_err0, overflow0}, 0);
        chk("reset_fifo_idle", rx_idle1, 1);
        chk("reset_fifo_write", fifo_write1, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            bit8 = vt[i].b8; parity_en = vt[i].pen; odd_n_even = vt[i].odd;
            sb0.push_back('{vt[i].exp_byte, vt[i].exp_perr, vt[i].exp_ferr, 1'b0});
            send_frame(1'b0, vt[i].data, vt[i].b8, vt[i].pen, vt[i].odd, vt[i].flip,
                       vt[i].stop_v, BIT_CLKS);
            check_frame0($sformatf("vec%0d", i));
            clear_all();
            chk($sformatf("vec%0d_cleared", i), {rx_ready0, parity_err0, framing_err0}, 0);
        end

        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        busy = 1'b0;
        for (int k = 0; k < 92; k++) begin
            rx0 = (k < 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (!rx_idle0) busy = 1'b1;
        end
        chk("glitch_reached_start", busy, 1);
        chk("glitch_back_idle", rx_idle0, 1);
        chk("glitch_no_output", {rx_ready0, parity_err0, framing_err0, overflow0}, 0);

        sb0.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        check_frame0("ovf_a");
        sb0.push_back('{8'h22, 1'b0, 1'b0, 1'b1});
        align_baud();
        fork
            send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
            begin
                lat = 0;
                while (rx_byte0 !== 8'h22 && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_frame0("ovf_b");
        chk("frame_latency_window", (lat >= 608 && lat <= 618), 1);
        clear_all();
        chk("ovf_cleared_by_read", {rx_ready0, overflow0}, 0);

        sb0.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        check_frame0("rdc_a");
        sb0.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
        align_baud();
        fork
            send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
            begin
                repeat (lat - 1) @(negedge clk);
                read_rx_byte = 1'b1;
                @(negedge clk);
                read_rx_byte = 1'b0;
            end
        join
        check_frame0("rdc_b");
        clear_all();

        sb0.push_back('{8'h00, 1'b0, 1'b1, 1'b0});
        fork
            send_frame(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BIT_CLKS + 400);
            begin
                repeat (BIT_CLKS * 10) @(negedge clk);
                busy = 1'b0;
                repeat (300) begin
                    @(negedge clk);
                    if (!rx_idle0) busy = 1'b1;
                end
            end
        join
        chk("break_hold_idle", busy, 0);
        check_frame0("break");
        clear_all();
        sb0.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        check_frame0("after_break");

        sb0.push_back('{8'h3C, 1'b0, 1'b1, 1'b1});
        send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BIT_CLKS);
        check_frame0("pre_reset");
        rx0 = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx0 = i[0] ? 1'b0 : 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx0 = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        chk("pre_reset_busy", rx_idle0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_idle", rx_idle0, 1);
        chk("midreset_flags", {rx_ready0, parity_err0, framing_err0, overflow0}, 0);
        chk("midreset_rx_byte", rx_byte0, 0);
        reset = 1'b0;
        repeat (BIT_CLKS * 4) @(negedge clk);
        sb0.push_back('{8'h7E, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        check_frame0("post_reset");

        for (int i = 0; i < 3; i++) begin
            fifo_full = (i == 2);
            sbf.push_back('{8'(i + 1), (i == 2)});
            send_frame(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        end
        fifo_full = 1'b0;
        repeat (10) @(negedge clk);
        chk("fifo_pulse_count", fw_count, 3);
        chk("fifo_sb_drained", sbf.size(), 0);
        chk("fifo_overflow_sticky", overflow1, 1);
        chk("fifo_rx_ready_low", rx_ready1, 0);
        chk("hold_mode_no_fifo_write", fw0_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
- Asynchronous UART receiver; the receive-side counterpart of the transmitter in the CoreUARTapb core.
- Oversamples the serial line at 16x the bit rate using the shared baud_clock enable.
- Validates the start bit, deserialises 7 or 8 data bits LSB-first, and checks optional parity and the stop bit.
- Delivers each byte to the APB register side, or to an external RX FIFO, together with sticky error flags.

Parameters:
RX_FIFO, 0, 0 = single holding register with rx_ready/read handshake; 1 = push every received byte to an external FIFO.

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous active-high reset
baud_clock  input  1  one-clk-wide enable pulse at 16x the bit rate
rx  input  1  asynchronous serial input; idle level is high
bit8  input  1  1 = 8 data bits, 0 = 7 data bits
parity_en  input  1  a parity bit follows the data bits
odd_n_even  input  1  1 = odd parity, 0 = even parity
read_rx_byte  input  1  one-cycle pulse from the register block that consumes the held byte
clear_parity_err  input  1  one-cycle pulse that clears parity_err
clear_framing_err  input  1  one-cycle pulse that clears framing_err
fifo_full  input  1  external RX FIFO is full (used only when RX_FIFO=1)
rx_byte  output  8  last received byte; bit 7 is 0 in 7-bit mode
rx_ready  output  1  holding register contains an unread byte
fifo_write  output  1  one-cycle push strobe; rx_byte is valid in the same cycle
parity_err  output  1  sticky parity error flag
framing_err  output  1  sticky framing error flag
overflow  output  1  sticky overflow flag; cleared by read_rx_byte
rx_idle  output  1  receive state machine is in IDLE

Behaviour:
- Reset values: all outputs 0 except rx_idle=1. Synchroniser flops reset to 1. State resets to IDLE; counters reset to 0.
- Synchronisation: rx passes through 2 flops to give rx_s. This adds 2 clk of latency.
- Sampling: the 4-bit sample counter advances only on baud_clock. All state transitions occur only on baud_clock cycles.
- IDLE: when rx_s=0, clear the sample counter and go to START.
- START: at count 7 (mid start bit), if rx_s=0, clear the counter and go to DATA. If rx_s=1, treat as a glitch and return to IDLE with no flags changed.
- DATA: at count 15 (mid bit), shift rx_s into the shift register MSB and right-shift, so the result is LSB-first. The bit counter increments. After 8 bits (bit8=1) or 7 bits (bit8=0), go to PARITY if parity_en=1, otherwise STOP. In 7-bit mode the byte is right-aligned and bit 7 is 0.
- PARITY: at count 15, the check is XOR(data bits, rx_s) must equal odd_n_even. On mismatch, latch a pending parity error. Go to STOP.
- STOP: at count 15:
  - If rx_s=0, set framing_err.
  - Load rx_byte and apply any pending parity error to parity_err.
  - Return to IDLE, so the next start bit can be detected in the same half-bit.
- Completion with RX_FIFO=0:
  - rx_ready is set.
  - If rx_ready was already 1 and read_rx_byte is not asserted in that cycle, set overflow. The new byte overwrites rx_byte.
- Completion with RX_FIFO=1:
  - fifo_write pulses for exactly one clk.
  - If fifo_full=1, set overflow and still pulse fifo_write; the FIFO drops the byte.
  - rx_ready stays 0.
- read_rx_byte clears rx_ready and overflow. When a read coincides with completion, rx_ready stays 1 and overflow is not set.
- Sticky flags: when a set condition and its clear pulse occur in the same cycle, set wins.
- Configuration: bit8, parity_en and odd_n_even are sampled live. Changing them mid-frame is undefined.
- Reset mid-frame: abort immediately to IDLE and clear all flags.
- Break condition (rx held low): produces a byte of 0x00 with framing_err=1. The receiver then waits in IDLE until rx_s returns to 1 before it accepts a new start bit; this is tracked by a break_seen flag.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - constants MID_START=4'd7 and MID_BIT=4'd15.
  The transmitter's state codes also move into this package.
- One sub-module, uart_rx_sync: a 2-flop synchroniser with reset value 1.
- Everything else stays flat in uart_rx_async.

Test Plan:
- 8N1, baud_clock every 4 clk, frame 0xA5 → rx_byte=0xA5 and rx_ready=1 about 2+16*9.5*4 clk after the start edge; parity_err, framing_err and overflow stay 0.
- 7E1, frame 0x53 with correct even parity bit 0 → rx_byte=0x53, parity_err=0. Repeat with the parity bit flipped → parity_err=1; a clear_parity_err pulse then returns it to 0.
- 8N1, frame 0x3C with the stop bit driven 0 → framing_err=1, rx_byte=0x3C. A 3-sample low glitch on an idle line → no state change beyond START and rx_idle returns to 1.
- Two back-to-back 0x11 and 0x22 with no read → overflow=1 and rx_byte=0x22. Repeat with read_rx_byte asserted in the completion cycle → overflow=0.
- RX_FIFO=1, three frames 0x01, 0x02, 0x03 → three single-clk fifo_write pulses with matching rx_byte; fifo_full=1 on the third → overflow=1.
- Reset asserted during DATA bit 4 → next clk: rx_idle=1, all flags 0. A following clean frame 0x7E is received correctly.
